aes_round_key_store_128: RTL and testbench

//  Captures the AES-128 round-key stream from the key-expansion stage: rk[0] = short_key on start,

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_round_key_store_128.sv | 110 +++++++++++
 tb/tb_aes_round_key_store_128.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, round index type, store states.
package aes_pkg;

  localparam int AES128_KW = 128;
  localparam int AES128_NR = 10;
  localparam int AES128_CW = 4;

  typedef logic [AES128_CW-1:0] round_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } ks_state_t;

endpackage

// File: rtl/aes_round_key_store_128.sv
// AES-128 round-key store.
// Captures rk[0] from the cipher key on ke_start and rk[1..NR] as the key
// expander streams them out in order. Once every key is held, it serves them
// through a registered read port with one cycle of latency.
//
// state | meaning
// IDLE  | no valid key set (after reset or an out-of-order stream)
// LOAD  | collecting rk[exp] from the expander
// READY | all NR+1 keys held; reads are served
module aes_round_key_store_128
  import aes_pkg::*;
#(
  parameter int KW = AES128_KW,
  parameter int NR = AES128_NR,
  parameter int CW = AES128_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ke_start,
  input  logic [KW-1:0] ke_short_key,
  input  logic [KW-1:0] ke_subkey,
  input  logic [CW-1:0] ke_cnt,
  input  logic          ke_valid,
  input  logic          rd_req,
  input  logic [CW-1:0] rd_round,
  output logic [KW-1:0] rd_key,
  output logic          rd_valid,
  output logic          rd_miss,
  output logic          keys_ready,
  output logic          busy,
  output logic          seq_err
);

  localparam logic [CW-1:0] NR_IDX  = CW'(NR);
  localparam logic [CW-1:0] ONE_IDX = CW'(1);

  ks_state_t     state_q, state_d;
  logic [CW-1:0] exp_q;
  logic          seq_err_q;
  logic          capture;
  logic          mismatch;
  logic          rd_hit;
  logic [KW-1:0] rk [0:NR];

  // Next-state decode; ke_start wins over any expander beat in the same cycle.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    mismatch = 1'b0;
    if (ke_start) begin
      state_d = LOAD;
    end else if (state_q == LOAD && ke_valid) begin
      if (ke_cnt == exp_q) begin
        capture = 1'b1;
        if (exp_q == NR_IDX) state_d = READY;
      end else begin
        mismatch = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Expected-index tracker and sticky sequence error.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q     <= '0;
      seq_err_q <= 1'b0;
    end else if (ke_start) begin
      exp_q     <= ONE_IDX;
      seq_err_q <= 1'b0;
    end else if (capture) begin
      exp_q     <= exp_q + ONE_IDX;
    end else if (mismatch) begin
      seq_err_q <= 1'b1;
    end
  end

  // Key register file; contents are only exposed once READY, so no reset.
  always_ff @(posedge clk) begin
    if (ke_start)     rk[0]     <= ke_short_key;
    else if (capture) rk[exp_q] <= ke_subkey;
  end

  assign rd_hit = rd_req && (state_q == READY) && (rd_round <= NR_IDX);

  // Registered read port: hit returns the key, refused request zeroes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_key   <= '0;
      rd_valid <= 1'b0;
      rd_miss  <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      rd_miss  <= rd_req && !rd_hit;
      if (rd_hit)      rd_key <= rk[rd_round];
      else if (rd_req) rd_key <= '0;
    end
  end

  assign keys_ready = (state_q == READY);
  assign busy       = (state_q == LOAD);
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_aes_round_key_store_128.sv
// Self-checking bench for aes_round_key_store_128: a real AES-128 key schedule
// computed in the bench feeds directed scenarios and a randomized run, all
// checked cycle by cycle against a behavioural model of the store.
module tb_aes_round_key_store_128;

  logic         clk = 1'b0;
  logic         reset;
  logic         ke_start;
  logic [127:0] ke_short_key;
  logic [127:0] ke_subkey;
  logic [3:0]   ke_cnt;
  logic         ke_valid;
  logic         rd_req;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_miss;
  logic         keys_ready;
  logic         busy;
  logic         seq_err;

  int n_cmp = 0;
  int n_err = 0;

  aes_round_key_store_128 dut (
    .clk(clk), .reset(reset),
    .ke_start(ke_start), .ke_short_key(ke_short_key), .ke_subkey(ke_subkey),
    .ke_cnt(ke_cnt), .ke_valid(ke_valid),
    .rd_req(rd_req), .rd_round(rd_round),
    .rd_key(rd_key), .rd_valid(rd_valid), .rd_miss(rd_miss),
    .keys_ready(keys_ready), .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // ---------------- AES-128 key schedule (reference expander) ----------------
  logic [127:0] exp_keys [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic compute_keys(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- behavioural model of the store ----------------
  logic [127:0] m_keys [0:10];
  int           m_exp;
  bit           m_loading, m_ready, m_err;
  logic [127:0] e_key;
  bit           e_valid, e_miss;

  task automatic model_step();
    if (rd_req) begin
      if (m_ready && rd_round <= 4'd10) begin
        e_key = m_keys[rd_round]; e_valid = 1; e_miss = 0;
      end else begin
        e_key = '0; e_valid = 0; e_miss = 1;
      end
    end else begin
      e_valid = 0; e_miss = 0;
    end
    if (ke_start) begin
      m_keys[0] = ke_short_key;
      m_exp = 1; m_ready = 0; m_err = 0; m_loading = 1;
    end else if (m_loading && ke_valid) begin
      if (int'(ke_cnt) == m_exp) begin
        m_keys[m_exp] = ke_subkey;
        if (m_exp == 10) begin m_loading = 0; m_ready = 1; end
        m_exp++;
      end else begin
        m_err = 1; m_loading = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_all();
    chk("rd_key", rd_key, e_key);
    chk("rd_valid", 128'(rd_valid), 128'(e_valid));
    chk("rd_miss", 128'(rd_miss), 128'(e_miss));
    chk("keys_ready", 128'(keys_ready), 128'(m_ready));
    chk("busy", 128'(busy), 128'(m_loading));
    chk("seq_err", 128'(seq_err), 128'(m_err));
  endtask

  task automatic idle_inputs();
    ke_start = 0; ke_short_key = '0; ke_subkey = '0; ke_cnt = '0; ke_valid = 0;
    rd_req = 0; rd_round = '0;
  endtask

  // One clock: drive at negedge, step model, clock, compare at next negedge.
  task automatic cycle(input bit st, input logic [127:0] sk, input bit v, input logic [3:0] c,
                       input logic [127:0] sub, input bit rq, input logic [3:0] rr);
    ke_start = st; ke_short_key = sk; ke_valid = v; ke_cnt = c; ke_subkey = sub;
    rd_req = rq; rd_round = rr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk_all();
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    m_loading = 0; m_ready = 0; m_err = 0; m_exp = 0;
    e_key = '0; e_valid = 0; e_miss = 0;
    chk_all();
    reset = 0;
  endtask

  // Full expander stream with an optional stall inserted before index stall_at.
  task automatic load_stream(input logic [127:0] key, input int stall_at, input int stall_len);
    compute_keys(key);
    cycle(1, key, 0, 0, '0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      if (i == stall_at)
        for (int s = 0; s < stall_len; s++) begin
          cycle(0, '0, 0, 0, '0, 0, 0);
          chk("ready_during_stall", 128'(keys_ready), 128'(0));
        end
      if (i == 10) chk("ready_before_last", 128'(keys_ready), 128'(0));
      cycle(0, '0, 1, 4'(i), exp_keys[i], 0, 0);
    end
    chk("ready_after_last", 128'(keys_ready), 128'(1));
  endtask

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
    bit           valid;
    bit           miss;
  } rd_vec_t;

  rd_vec_t tbl [0:12];

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    logic [127:0] rkey;
    idle_inputs();
    reset = 1;
    m_loading = 0; m_ready = 0; m_err = 0; m_exp = 0;
    e_key = '0; e_valid = 0; e_miss = 0;
    @(negedge clk);
    do_reset();

    // T1: FIPS-197 key, then table-driven reads of every round plus out-of-range.
    load_stream(KEY_A, 0, 0);
    for (int i = 0; i <= 10; i++) tbl[i] = '{4'(i), exp_keys[i], 1, 0};
    tbl[0].key   = KEY_A;
    tbl[10].key  = KEY_A10;
    tbl[11] = '{4'd11, '0, 0, 1};
    tbl[12] = '{4'd15, '0, 0, 1};
    for (int i = 0; i <= 12; i++) begin
      cycle(0, '0, 0, 0, '0, 1, tbl[i].round);
      chk("t1_key", rd_key, tbl[i].key);
      chk("t1_valid", 128'(rd_valid), 128'(tbl[i].valid));
      chk("t1_miss", 128'(rd_miss), 128'(tbl[i].miss));
    end
    cycle(0, '0, 0, 0, '0, 0, 0);
    chk("t1_hold_key", rd_key, '0);

    // T2: read during LOAD misses; index 11 while READY misses.
    compute_keys(KEY_A);
    cycle(1, KEY_A, 0, 0, '0, 0, 0);
    cycle(0, '0, 1, 4'd1, exp_keys[1], 1, 4'd3);
    chk("t2_load_miss", 128'(rd_miss), 128'(1));
    chk("t2_load_valid", 128'(rd_valid), 128'(0));
    for (int i = 2; i <= 10; i++) cycle(0, '0, 1, 4'(i), exp_keys[i], 0, 0);
    cycle(0, '0, 0, 0, '0, 1, 4'd11);
    chk("t2_range_miss", 128'(rd_miss), 128'(1));

    // T3: ke_cnt 1,2,4 -> sequence error, back to IDLE, start clears it.
    cycle(1, KEY_B, 0, 0, '0, 0, 0);
    cycle(0, '0, 1, 4'd1, 128'h1, 0, 0);
    cycle(0, '0, 1, 4'd2, 128'h2, 0, 0);
    cycle(0, '0, 1, 4'd4, 128'h4, 0, 0);
    chk("t3_seq_err", 128'(seq_err), 128'(1));
    chk("t3_busy", 128'(busy), 128'(0));
    chk("t3_ready", 128'(keys_ready), 128'(0));
    cycle(0, '0, 0, 0, '0, 1, 4'd0);
    chk("t3_idle_miss", 128'(rd_miss), 128'(1));
    cycle(1, KEY_B, 0, 0, '0, 0, 0);
    chk("t3_err_clear", 128'(seq_err), 128'(0));

    // T4: 3-cycle stall between indices 5 and 6; all keys still intact.
    load_stream(KEY_A, 6, 3);
    for (int i = 0; i <= 10; i++) cycle(0, '0, 0, 0, '0, 1, 4'(i));
    cycle(0, '0, 0, 0, '0, 1, 4'd10);
    chk("t4_rk10", rd_key, KEY_A10);

    // T5: restart while READY with a same-cycle read of round 0.
    compute_keys(KEY_B);
    cycle(1, KEY_B, 0, 0, '0, 1, 4'd0);
    chk("t5_old_rk0", rd_key, KEY_A);
    chk("t5_valid", 128'(rd_valid), 128'(1));
    chk("t5_not_ready", 128'(keys_ready), 128'(0));
    for (int i = 1; i <= 10; i++) cycle(0, '0, 1, 4'(i), exp_keys[i], 0, 0);
    cycle(0, '0, 0, 0, '0, 1, 4'd10);
    chk("t5_new_rk10", rd_key, KEY_B10);
    cycle(0, '0, 0, 0, '0, 1, 4'd0);
    chk("t5_new_rk0", rd_key, KEY_B);

    // T6: reset at T+5 of a load; later beats ignored, reads miss.
    compute_keys(KEY_A);
    cycle(1, KEY_A, 0, 0, '0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, '0, 1, 4'(i), exp_keys[i], 0, 0);
    do_reset();
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_key", rd_key, '0);
    cycle(0, '0, 1, 4'd5, exp_keys[5], 0, 0);
    chk("t6_ignored_err", 128'(seq_err), 128'(0));
    chk("t6_ignored_busy", 128'(busy), 128'(0));
    cycle(0, '0, 0, 0, '0, 1, 4'd0);
    chk("t6_read_miss", 128'(rd_miss), 128'(1));

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        rkey = {$urandom, $urandom, $urandom, $urandom};
        cycle($urandom_range(0, 24) == 0,
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 3) != 0,
              ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_exp),
              rkey,
              $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 12)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
